// File: rtl/zap_branch_predict_ctrl.sv
// zap_branch_predict_ctrl
// Owns the write port of the 2-bit-per-entry branch predictor RAM.
// After reset or a flush request it sweeps every entry to INIT_STATE.
// ALU train/untrain updates are arbitrated against that sweep through a
// one-deep pending buffer. Predictions are not valid while o_busy is high.
module zap_branch_predict_ctrl #(
  parameter int         BP_ENTRIES = 512,
  parameter logic [1:0] INIT_STATE = 2'd0,
  localparam int        AW         = $clog2(BP_ENTRIES)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_data_stall,
  input  logic          i_upd_valid,
  input  logic [AW-1:0] i_upd_addr,
  input  logic [1:0]    i_upd_data,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [1:0]    o_wr_data,
  output logic          o_busy,
  output logic          o_init_done,
  output logic          o_upd_drop
);

  // ST_LAST is the cycle after the final sweep address has been driven.
  // The edge leaving it ends the sweep and also acts as the first idle
  // edge, so the pending buffer drains on that same edge.
  localparam logic [1:0] ST_SWEEP = 2'd0;
  localparam logic [1:0] ST_LAST  = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(BP_ENTRIES - 1);

  logic [1:0]    state_reg;
  logic [AW:0]   cnt_reg;
  logic          buf_valid_reg;
  logic [AW-1:0] buf_addr_reg;
  logic [1:0]    buf_data_reg;
  logic          wr_en_reg;
  logic [AW-1:0] wr_addr_reg;
  logic [1:0]    wr_data_reg;
  logic          busy_reg;
  logic          init_done_reg;
  logic          upd_drop_reg;

  logic acc;
  logic same_addr;

  assign acc       = i_upd_valid & ~i_data_stall;
  assign same_addr = (buf_addr_reg == i_upd_addr);

  // Sweep sequencing, update arbitration and registered RAM write port.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg     <= ST_SWEEP;
      cnt_reg       <= '0;
      buf_valid_reg <= 1'b0;
      buf_addr_reg  <= '0;
      buf_data_reg  <= 2'd0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= 2'd0;
      busy_reg      <= 1'b1;
      init_done_reg <= 1'b0;
      upd_drop_reg  <= 1'b0;
    end else begin
      wr_en_reg     <= 1'b0;
      init_done_reg <= 1'b0;
      upd_drop_reg  <= 1'b0;
      if (i_flush) begin
        // Restart the sweep; any pending or same-cycle update is discarded.
        state_reg     <= ST_SWEEP;
        cnt_reg       <= '0;
        buf_valid_reg <= 1'b0;
        busy_reg      <= 1'b1;
      end else begin
        case (state_reg)
          ST_SWEEP: begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= cnt_reg[AW-1:0];
            wr_data_reg <= INIT_STATE;
            cnt_reg     <= cnt_reg + 1'b1;
            busy_reg    <= 1'b1;
            if (cnt_reg == LAST_IDX) begin
              state_reg <= ST_LAST;
            end
            // Updates park in the buffer; a newer one replaces an older one.
            if (acc) begin
              buf_valid_reg <= 1'b1;
              buf_addr_reg  <= i_upd_addr;
              buf_data_reg  <= i_upd_data;
              if (buf_valid_reg && !same_addr) begin
                upd_drop_reg <= 1'b1;
              end
            end
          end
          default: begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
            if (state_reg == ST_LAST) begin
              init_done_reg <= 1'b1;
            end
            if (buf_valid_reg) begin
              wr_en_reg <= 1'b1;
              if (acc && same_addr) begin
                // Newer data for the same entry supersedes the buffered one.
                wr_addr_reg   <= i_upd_addr;
                wr_data_reg   <= i_upd_data;
                buf_valid_reg <= 1'b0;
              end else begin
                wr_addr_reg   <= buf_addr_reg;
                wr_data_reg   <= buf_data_reg;
                buf_valid_reg <= acc;
                buf_addr_reg  <= i_upd_addr;
                buf_data_reg  <= i_upd_data;
              end
            end else if (acc) begin
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= i_upd_addr;
              wr_data_reg <= i_upd_data;
            end
          end
        endcase
      end
    end
  end

  assign o_wr_en     = wr_en_reg;
  assign o_wr_addr   = wr_addr_reg;
  assign o_wr_data   = wr_data_reg;
  assign o_busy      = busy_reg;
  assign o_init_done = init_done_reg;
  assign o_upd_drop  = upd_drop_reg;

endmodule

// File: tb/tb_zap_branch_predict_ctrl.sv
// Testbench for zap_branch_predict_ctrl (8 entries, INIT_STATE=1).
// Directed scenarios followed by a randomized run; every cycle is checked
// against a behavioural model built from a sweep position and a pending queue.
module tb_zap_branch_predict_ctrl;

  localparam int         N    = 8;
  localparam int         AW   = 3;
  localparam logic [1:0] INIT = 2'd1;

  logic          i_clk;
  logic          i_reset;
  logic          i_flush;
  logic          i_data_stall;
  logic          i_upd_valid;
  logic [AW-1:0] i_upd_addr;
  logic [1:0]    i_upd_data;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [1:0]    o_wr_data;
  logic          o_busy;
  logic          o_init_done;
  logic          o_upd_drop;

  zap_branch_predict_ctrl #(
    .BP_ENTRIES (N),
    .INIT_STATE (INIT)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_flush      (i_flush),
    .i_data_stall (i_data_stall),
    .i_upd_valid  (i_upd_valid),
    .i_upd_addr   (i_upd_addr),
    .i_upd_data   (i_upd_data),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_init_done  (o_init_done),
    .o_upd_drop   (o_upd_drop)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Compare one observed value with its expected value.
  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [1:0]    d;
  } upd_t;

  upd_t pend[$];
  bit   sweeping;
  int   next_pos;     // next sweep address; N means the sweep-finishing edge
  logic          e_wr_en, e_busy, e_done, e_drop;
  logic [AW-1:0] e_addr;
  logic [1:0]    e_data;

  task automatic idle_edge(input bit acc, input logic [AW-1:0] a, input logic [1:0] d);
    upd_t u;
    u.a = a;
    u.d = d;
    if (pend.size() != 0) begin
      e_wr_en = 1'b1;
      if (acc && pend[0].a == a) begin
        e_addr = a;
        e_data = d;
        pend.delete();
      end else begin
        e_addr = pend[0].a;
        e_data = pend[0].d;
        pend.delete();
        if (acc) pend.push_back(u);
      end
    end else if (acc) begin
      e_wr_en = 1'b1;
      e_addr  = a;
      e_data  = d;
    end
  endtask

  task automatic model_edge(input bit r, input bit f, input bit acc,
                            input logic [AW-1:0] a, input logic [1:0] d);
    upd_t u;
    u.a = a;
    u.d = d;
    if (r) begin
      sweeping = 1; next_pos = 0; pend.delete();
      e_wr_en = 0; e_addr = '0; e_data = '0; e_busy = 1; e_done = 0; e_drop = 0;
      return;
    end
    e_wr_en = 0; e_done = 0; e_drop = 0;
    if (f) begin
      sweeping = 1; next_pos = 0; pend.delete(); e_busy = 1;
    end else if (sweeping && next_pos < N) begin
      e_wr_en = 1; e_addr = AW'(next_pos); e_data = INIT; e_busy = 1;
      next_pos++;
      if (acc) begin
        if (pend.size() != 0 && pend[0].a != a) e_drop = 1;
        pend.delete();
        pend.push_back(u);
      end
    end else begin
      if (sweeping) e_done = 1;
      sweeping = 0;
      e_busy   = 0;
      idle_edge(acc, a, d);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input bit f, input bit s, input bit v,
                     input logic [AW-1:0] a, input logic [1:0] d);
    i_reset = r; i_flush = f; i_data_stall = s; i_upd_valid = v;
    i_upd_addr = a; i_upd_data = d;
    @(posedge i_clk);
    model_edge(r, f, v & ~s, a, d);
    #1;
    chk_eq("wr_en", o_wr_en, e_wr_en);
    chk_eq("wr_addr", o_wr_addr, e_addr);
    chk_eq("wr_data", o_wr_data, e_data);
    chk_eq("busy", o_busy, e_busy);
    chk_eq("init_done", o_init_done, e_done);
    chk_eq("upd_drop", o_upd_drop, e_drop);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, '0, '0);
    cyc(1, 0, 0, 0, '0, '0);
    chk_eq("rst_busy", o_busy, 1);
    chk_eq("rst_wr_en", o_wr_en, 0);
  endtask

  int flush_left;
  int seen_done;

  initial begin
    i_reset = 1; i_flush = 0; i_data_stall = 0; i_upd_valid = 0;
    i_upd_addr = '0; i_upd_data = '0;

    // 1: power-up sweep
    do_reset();
    seen_done = -1;
    for (int i = 0; i <= 9; i++) begin
      cyc(0, 0, 0, 0, '0, '0);
      if (i < 8) begin
        chk_eq("s1_sweep_en", o_wr_en, 1);
        chk_eq("s1_sweep_addr", o_wr_addr, i);
        chk_eq("s1_sweep_data", o_wr_data, 2'd1);
      end
      if (o_init_done === 1'b1) seen_done = i + 1;
    end
    chk_eq("s1_done_cycle", seen_done, 9);
    $display("scenario 1: sweep of %0d entries, init_done at cycle %0d", N, seen_done);

    // 2: direct update, then stalled update
    cyc(0, 0, 0, 1, 3'd3, 2'd2);
    chk_eq("s2_wr_en", o_wr_en, 1);
    chk_eq("s2_addr", o_wr_addr, 3);
    chk_eq("s2_data", o_wr_data, 2);
    cyc(0, 0, 1, 1, 3'd3, 2'd2);
    chk_eq("s2_stall_wr", o_wr_en, 0);
    $display("scenario 2: direct update (3,2) and stalled repeat");

    // 3: two different updates during sweep -> drop; same address -> none
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      if (i == 2)      cyc(0, 0, 0, 1, 3'd5, 2'd3);
      else if (i == 5) cyc(0, 0, 0, 1, 3'd6, 2'd0);
      else             cyc(0, 0, 0, 0, '0, '0);
      if (i == 5) chk_eq("s3_drop", o_upd_drop, 1);
      if (i == 8) begin
        chk_eq("s3_drain_addr", o_wr_addr, 6);
        chk_eq("s3_drain_data", o_wr_data, 0);
      end
    end
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      if (i == 2 || i == 5) cyc(0, 0, 0, 1, 3'd5, 2'(i & 3));
      else                  cyc(0, 0, 0, 0, '0, '0);
      if (i == 5) chk_eq("s3_coalesce_drop", o_upd_drop, 0);
    end
    $display("scenario 3: drop on differing address, none on coalesce");

    // 4: flush mid-sweep at address 4
    do_reset();
    for (int i = 0; i < 25; i++) begin
      cyc(0, (i == 5), 0, 0, '0, '0);
      if (i == 5) chk_eq("s4_flush_wr", o_wr_en, 0);
      if (i == 6) chk_eq("s4_restart_addr", o_wr_addr, 0);
      if (i == 14) chk_eq("s4_done", o_init_done, 1);
    end
    $display("scenario 4: flush at sweep address 4");

    // 5: buffered update meets a same / different address on the final sweep edge
    do_reset();
    for (int i = 0; i <= 11; i++) begin
      if (i == 3)      cyc(0, 0, 0, 1, 3'd2, 2'd1);
      else if (i == 8) cyc(0, 0, 0, 1, 3'd2, 2'd3);
      else             cyc(0, 0, 0, 0, '0, '0);
      if (i == 8) begin
        chk_eq("s5_same_addr", o_wr_addr, 2);
        chk_eq("s5_same_data", o_wr_data, 3);
      end
      if (i == 9) chk_eq("s5_single_write", o_wr_en, 0);
    end
    do_reset();
    for (int i = 0; i <= 11; i++) begin
      if (i == 3)      cyc(0, 0, 0, 1, 3'd2, 2'd1);
      else if (i == 8) cyc(0, 0, 0, 1, 3'd4, 2'd2);
      else             cyc(0, 0, 0, 0, '0, '0);
      if (i == 8) chk_eq("s5_first_data", o_wr_data, 1);
      if (i == 9) begin
        chk_eq("s5_second_addr", o_wr_addr, 4);
        chk_eq("s5_second_data", o_wr_data, 2);
      end
    end
    $display("scenario 5: coalesce and back-to-back drain");

    // 6: reset in IDLE with a buffered update
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      if (i == 3)      cyc(0, 0, 0, 1, 3'd2, 2'd1);
      else if (i == 8) cyc(0, 0, 0, 1, 3'd4, 2'd2);
      else             cyc(0, 0, 0, 0, '0, '0);
    end
    cyc(1, 0, 0, 0, '0, '0);
    chk_eq("s6_drop", o_upd_drop, 0);
    chk_eq("s6_wr_en", o_wr_en, 0);
    cyc(0, 0, 0, 0, '0, '0);
    chk_eq("s6_restart_addr", o_wr_addr, 0);
    idle(12);
    $display("scenario 6: reset with buffered update");

    // Randomized run
    flush_left = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r;
      r = ($urandom_range(0, 499) == 0);
      if (flush_left == 0 && $urandom_range(0, 59) == 0) flush_left = $urandom_range(1, 3);
      cyc(r, (flush_left != 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1) != 0,
          AW'($urandom_range(0, N - 1)), 2'($urandom_range(0, 3)));
      if (flush_left != 0) flush_left--;
    end
    $display("random: 4000 cycles applied");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
